// File: rtl/wb_openram_port.sv
// Wishbone classic slave fronting one 1RW port of an OpenRAM 32-bit SRAM macro.
// Every bus access becomes a single registered macro command; reads wait out the macro latency.
module wb_openram_port #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_W       = 8,
    parameter int          READ_LATENCY = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              ram_csb_o,
    output logic              ram_web_o,
    output logic [3:0]        ram_wmask_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_din_o,
    input  logic [31:0]       ram_dout_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              hit;
    logic              unused_adr_lsbs;

    // Byte lanes within a word are chosen by sel, so the low address bits carry no information.
    assign unused_adr_lsbs = ^wbs_adr_i[1:0];

    assign hit = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    addr_d  = wbs_adr_i[ADDR_W+1:2];
                    web_d   = ~wbs_we_i;
                    wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                    din_d   = wbs_dat_i;
                    csb_d   = 1'b0;
                    state_d = CMD;
                end
            end
            // The macro samples the command at the end of CMD; a write is committed even if cyc drops here.
            CMD: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (!web_q) begin
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d   = 2'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 2'd0) begin
                    dat_d   = ram_dout_i;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            // Always back to IDLE so a strobe still held during the ack cycle cannot retrigger.
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            ack_q   <= 1'b0;
            dat_q   <= 32'd0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'b0000;
            addr_q  <= '0;
            din_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign ram_csb_o   = csb_q;
    assign ram_web_o   = web_q;
    assign ram_wmask_o = wmask_q;
    assign ram_addr_o  = addr_q;
    assign ram_din_o   = din_q;

endmodule

// File: tb/tb_wb_openram_port.sv
// Directed bench for wb_openram_port with a behavioural SRAM macro and a read-data scoreboard.
module tb_wb_openram_port;

    localparam int ADDR_W = 8;
    localparam int RL     = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cyc, stb, we;
    logic [3:0]        sel;
    logic [31:0]       adr, dat;
    logic              ack;
    logic [31:0]       dat_o;
    logic              ram_csb, ram_web;
    logic [3:0]        ram_wmask;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    wb_openram_port #(
        .BASE_ADDR(32'h3000_0000),
        .ADDR_W(ADDR_W),
        .READ_LATENCY(RL)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i(we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .ram_csb_o(ram_csb),
        .ram_web_o(ram_web),
        .ram_wmask_o(ram_wmask),
        .ram_addr_o(ram_addr),
        .ram_din_o(ram_din),
        .ram_dout_i(ram_dout)
    );

    // Behavioural OpenRAM macro: command sampled on the clock edge, read data one cycle later.
    always @(posedge clk) begin
        if (!ram_csb) begin
            if (!ram_web) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},   {31'd0, ack},       32'd0);
        check({tag, "_dat"},   dat_o,              32'd0);
        check({tag, "_csb"},   {31'd0, ram_csb},   32'd1);
        check({tag, "_web"},   {31'd0, ram_web},   32'd1);
        check({tag, "_wmask"}, {28'd0, ram_wmask}, 32'd0);
        check({tag, "_addr"},  {24'd0, ram_addr},  32'd0);
        check({tag, "_din"},   ram_din,            32'd0);
    endtask

    // Full bus transfer; linger keeps the strobe up through the ack cycle.
    task automatic wb_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input bit linger);
        int          lat, csb_lo, spur;
        bit          got;
        logic [31:0] e;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        end else begin
            exp_q.push_back(ref_mem[a[9:2]]);
        end
        lat = 0; csb_lo = 0; got = 1'b0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(posedge clk); #1;
            if (!ram_csb) begin
                csb_lo++;
                check({tag, "_addr"},  {24'd0, ram_addr},  {24'd0, a[9:2]});
                check({tag, "_web"},   {31'd0, ram_web},   {31'd0, ~w});
                check({tag, "_wmask"}, {28'd0, ram_wmask}, {28'd0, (w ? s : 4'h0)});
                if (w) check({tag, "_din"}, ram_din, d);
            end
            if (ack) begin
                got = 1'b1;
                lat = n;
            end
        end
        check({tag, "_ack_cycle"}, lat, w ? 2 : 2 + RL);
        check({tag, "_csb_pulses"}, csb_lo, 1);
        if (!w) begin
            e = exp_q.pop_front();
            if (got) check({tag, "_rdata"}, dat_o, e);
            last_rd = e;
        end
        if (linger) begin
            @(posedge clk); #1;
        end
        bus_idle();
        if (linger) begin
            spur = (!ram_csb || ack) ? 1 : 0;
            for (int n = 0; n < 3; n++) begin
                @(posedge clk); #1;
                if (!ram_csb || ack) spur++;
            end
            check({tag, "_no_retrigger"}, spur, 0);
        end
    endtask

    task automatic wb_miss(input string tag, input logic [31:0] a);
        int csb_lo, acks;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        csb_lo = 0; acks = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (!ram_csb) csb_lo++;
            if (ack) acks++;
        end
        check({tag, "_csb_lo"}, csb_lo, 0);
        check({tag, "_acks"}, acks, 0);
        bus_idle();
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        last_rd = 32'h0;
        bus_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        wb_xfer("t1_wr", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        wb_xfer("t2_rd", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0);
        wb_xfer("t3_wr", 1'b1, 32'h3000_0004, 32'h0000_AA00, 4'b0010, 1'b0);
        wb_xfer("t3_rd", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0);
        check("t3_merge_model", dat_o, 32'hDEAD_AAEF);

        wb_xfer("sel0_wr", 1'b1, 32'h3000_0006, 32'hFFFF_FFFF, 4'h0, 1'b1);
        wb_xfer("sel0_rd", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b1);

        wb_miss("t4_miss", 32'h3000_0400);
        wb_miss("t4_miss_hi", 32'h3100_0000);
        wb_xfer("t4_top_wr", 1'b1, 32'h3000_03FC, 32'h1234_5678, 4'hF, 1'b0);
        wb_xfer("t4_top_rd", 1'b0, 32'h3000_03FC, 32'h0, 4'hF, 1'b0);
        wb_xfer("t4_low_rd", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 1'b0);
        wb_xfer("t4_top_rd2", 1'b0, 32'h3000_03FC, 32'h0, 4'hF, 1'b0);

        // Read of 0xDEADAAEF abandoned in WAIT: no ack, output keeps 0x12345678.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_idle();
        acks = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check("t5_acks", acks, 0);
        check("t5_dat_hold", dat_o, last_rd);

        // Reset asserted while a read is in CMD.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
        @(posedge clk); #1;
        check("t6_in_cmd_csb", {31'd0, ram_csb}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values("t6_reset");
        bus_idle();
        rst_n = 1'b1;
        acks = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check("t6_acks", acks, 0);
        wb_xfer("t6_post_rd", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
